// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared types and constants for the nibble-serial CLA adder.
package cla_seq_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [NIBBLE_W-1:0] nibble_t;
endpackage

// File: rtl/cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder slice exposing c3 and c4.
module cla4_slice
  import cla_seq_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    c0,
  output nibble_t s,
  output logic    c3,
  output logic    c4
);
  nibble_t p, g;
  logic c1, c2;
  assign p  = a ^ b;
  assign g  = a & b;
  assign c1 = g[0] | (p[0] & c0);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c0);
  assign s  = p ^ {c3, c2, c1, c0};
endmodule

// File: rtl/cla_nibble_seq.sv
// cla_nibble_seq: WIDTH-bit add/subtract by reusing one 4-bit CLA slice, LSB nibble first.
// Signed overflow output is generated only when CLA_SEQ_OVF_EN is defined.
module cla_nibble_seq
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  if (WIDTH % NIBBLE_W != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("cla_nibble_seq: WIDTH must be a multiple of 4 and >= 4");
  end
  state_t state, state_nx;
  logic [WIDTH-1:0] a_r, b_r;
  logic carry;
  logic [IDX_W-1:0] idx;
  nibble_t s_n;
  logic c3, c4, last, accept;
  assign last      = idx == IDX_W'(NIBBLES - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign accept    = in_valid && in_ready;
  cla4_slice u_slice (
    .a (a_r[idx*NIBBLE_W +: NIBBLE_W]),
    .b (b_r[idx*NIBBLE_W +: NIBBLE_W]),
    .c0(carry),
    .s (s_n),
    .c3(c3),
    .c4(c4)
  );
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) :
                               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b ^ {WIDTH{op_sub}};
      carry <= op_sub | cin;
      idx   <= '0;
      sum   <= '0;
    end else if (state == RUN) begin
      sum[idx*NIBBLE_W +: NIBBLE_W] <= s_n;
      carry <= c4;
      if (last) cout <= c4;
      else idx <= idx + 1'b1;
    end
  end
`ifdef CLA_SEQ_OVF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= 1'b0;
    else if (state == RUN && last) ovf <= c3 ^ c4;
`else
  logic unused_c3;
  assign unused_c3 = c3;
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_cla_nibble_seq.sv
// tb_cla_nibble_seq: directed and random checks of cla_nibble_seq against an arithmetic model.
module tb_cla_nibble_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, op_sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic in_ready, out_valid, cout, ovf;
  logic [15:0] sum;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  cla_nibble_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic ci,
                       input logic sub, input int hold);
    logic [15:0] bb;
    logic [16:0] full;
    logic exp_ovf;
    int n;
    bb   = sub ? ~y : y;
    full = {1'b0, x} + {1'b0, bb} + 17'(sub ? 1'b1 : ci);
`ifdef CLA_SEQ_OVF_EN
    exp_ovf = (x[15] == bb[15]) && (full[15] != x[15]);
`else
    exp_ovf = 1'b0;
`endif
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    a = x; b = y; cin = ci; op_sub = sub; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency", 32'(n), 32'd4);
    chk("sum", 32'(sum), 32'(full[15:0]));
    chk("cout", 32'(cout), 32'(full[16]));
    chk("ovf", 32'(ovf), 32'(exp_ovf));
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_sum", 32'(sum), 32'(full[15:0]));
      chk("hold_cout", 32'(cout), 32'(full[16]));
      chk("hold_ovf", 32'(ovf), 32'(exp_ovf));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 3);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);
    for (int i = 0; i < 24; i++)
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
